mdu_ctrl: RTL

//   Multi-cycle multiply/divide unit controller beside the EX-stage ALU.

---
 rtl/mdu_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the EX stage: latches one mult/div/mthi/mtlo
// command per start pulse, runs a fixed-length busy window, then commits HI/LO.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        dbg_state
);

  // Handshake: start is a one-cycle command valid with no ready; the hazard
  // unit stalls on busy|start, so a start that arrives during RUN is dropped.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        pend_hi;
  logic [31:0]        pend_lo;
  logic               pend_keep;

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor;
  logic [31:0]        sq;
  logic [31:0]        sr;
  logic [31:0]        uq;
  logic [31:0]        ur;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               is_long_op;
  logic               is_div_op;
  logic               div_by_zero;

  assign dbg_state = state;

  always_comb begin
    is_long_op  = (op == OP_MULT) || (op == OP_MULTU) ||
                  (op == OP_DIV)  || (op == OP_DIVU);
    is_div_op   = (op == OP_DIV) || (op == OP_DIVU);
    div_by_zero = (B == 32'd0);
    // A substitute divisor keeps the divider X-free; the result is discarded.
    divisor     = div_by_zero ? 32'd1 : B;
    prod_s      = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u      = {32'd0, A} * {32'd0, B};
    // The only signed quotient that overflows 32 bits wraps back to itself.
    if ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
      sq = 32'h8000_0000;
      sr = 32'd0;
    end else begin
      sq = $signed(A) / $signed(divisor);
      sr = $signed(A) % $signed(divisor);
    end
    uq = A / divisor;
    ur = A % divisor;
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = sr;            res_lo = sq;           end
      OP_DIVU:  begin res_hi = ur;            res_lo = uq;           end
      default:  begin res_hi = 32'd0;         res_lo = 32'd0;        end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      HI        <= 32'd0;
      LO        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_keep <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_long_op) begin
              pend_hi   <= res_hi;
              pend_lo   <= res_lo;
              pend_keep <= is_div_op && div_by_zero;
              cnt       <= is_div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              busy      <= 1'b1;
              state     <= RUN;
            end else if (op == OP_MTHI) begin
              HI <= A;
            end else if (op == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (!pend_keep) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
